// File: rtl/ua_receiver_if.sv
// Received-byte handshake bundle between the UART receiver and its consumer.
// The receiver drives the byte and status flags; the consumer returns dout_ack.
interface ua_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] dout_byte;
  logic                 dout_valid;
  logic                 dout_ack;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output dout_byte,
    output dout_valid,
    output frame_err,
    output overrun,
    input  dout_ack
  );

  modport slave (
    input  dout_byte,
    input  dout_valid,
    input  frame_err,
    input  overrun,
    output dout_ack
  );
endinterface

// File: rtl/ua_receiver.sv
// 8N1 LSB-first asynchronous serial receiver. It runs on the same oversample
// enable tick as the companion transmitter. The start bit is validated at its
// midpoint, and each data bit and the stop bit are sampled one full bit period
// after the previous sample. The result is presented with a valid/ack handshake.
module ua_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           ser_in,
  output logic           rx_busy,
  ua_receiver_if.master  rx_if
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   load;
  logic                   ferr;

  logic                   rx_sync_p0;
  logic                   rx_s;

  // Two-flop synchroniser; idle-high reset value so reset is not seen as a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_sync_p0 <= ser_in;
      rx_s       <= rx_sync_p0;
    end
  end

  // Frame state, oversample counter, bit index and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next-state decode; nothing moves on clocks without an oversample tick
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    load    = 1'b0;
    ferr    = 1'b0;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end
        ST_START: begin
          if (cnt_q == CNT_HALF) begin
            if (rx_s) begin
              // Line went high again before mid start bit: treat it as a glitch
              state_d = ST_IDLE;
            end else begin
              cnt_d   = '0;
              idx_d   = '0;
              state_d = ST_DATA;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_FULL) begin
            // LSB arrives first, so shifting right leaves it in bit 0
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            cnt_d   = '0;
            idx_d   = idx_q + IDX_ONE;
            if (idx_q == IDX_LAST) begin
              state_d = ST_STOP;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (cnt_q == CNT_FULL) begin
            // Leave at mid stop bit so a back-to-back start edge is not missed
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (rx_s) begin
              load = 1'b1;
            end else begin
              ferr = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign rx_busy = (state_q != ST_IDLE);

  // Output handshake runs every clock; a new byte takes priority over an ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_if.dout_byte  <= '0;
      rx_if.dout_valid <= 1'b0;
      rx_if.overrun    <= 1'b0;
      rx_if.frame_err  <= 1'b0;
    end else begin
      rx_if.frame_err <= ferr;
      if (load) begin
        rx_if.dout_byte  <= shift_q;
        rx_if.dout_valid <= 1'b1;
        if (rx_if.dout_ack) begin
          rx_if.overrun <= 1'b0;
        end else if (rx_if.dout_valid) begin
          rx_if.overrun <= 1'b1;
        end
      end else if (rx_if.dout_ack) begin
        rx_if.dout_valid <= 1'b0;
        rx_if.overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ua_receiver.sv
// Testbench for ua_receiver: directed scenarios plus random frames, checked
// against a frame-level model of the received byte and status flags.
`timescale 1ns/1ps
module tb_ua_receiver;

  localparam int OS = 16;
  localparam int DB = 8;
  localparam int LAT_DETECT = OS / 2 + (DB + 1) * OS;  // 152 ticks

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic ser_in = 1'b1;
  logic rx_busy;

  ua_receiver_if #(.DATA_BITS(DB)) rx_if();

  ua_receiver #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .ser_in  (ser_in),
    .rx_busy (rx_busy),
    .rx_if   (rx_if)
  );

  always #160 clk = ~clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  en_run  = 1'b1;
  int  phase   = 0;
  int  tick_cnt = 0;

  // monitor state
  bit  prev_busy = 1'b0;
  bit  prev_valid = 1'b0;
  int  busy_rise_tick = 0;
  int  busy_rises = 0;
  int  valid_rise_tick = 0;
  int  valid_rises = 0;
  bit  rise_busy_fall = 1'b0;
  int  ferr_hi = 0;
  int  last_start_tick = 0;

  // reference model
  logic [7:0] m_byte = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ovr = 1'b0;
  int         m_ferr = 0;

  // one enable tick every 4 clocks
  initial begin
    forever begin
      @(negedge clk);
      enable = en_run && (phase == 3);
      phase = (phase + 1) % 4;
    end
  end

  always @(posedge clk) if (enable) tick_cnt <= tick_cnt + 1;

  always @(negedge clk) begin
    if (rx_busy && !prev_busy) begin
      busy_rise_tick = tick_cnt;
      busy_rises++;
    end
    if (rx_if.dout_valid && !prev_valid) begin
      valid_rise_tick = tick_cnt;
      valid_rises++;
      rise_busy_fall = prev_busy && !rx_busy;
    end
    if (rx_if.frame_err) ferr_hi++;
    prev_busy  = rx_busy;
    prev_valid = rx_if.dout_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int target = tick_cnt + n;
    int guard = 0;
    while (tick_cnt < target && guard < n * 8 + 100) begin
      @(negedge clk);
      guard++;
    end
    if (tick_cnt < target) chk("tick_wait", tick_cnt, target);
  endtask

  task automatic idle_bits(input int n);
    ser_in = 1'b1;
    wait_ticks(n * OS);
  endtask

  // Drive one 8N1 frame; bit durations are counted in enable ticks so a pause
  // of the tick stream stretches the frame on the line as well.
  task automatic send_frame(input logic [7:0] d, input bit stop, input int pause_bit);
    last_start_tick = tick_cnt;
    ser_in = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      ser_in = d[i];
      if (i == pause_bit) begin
        wait_ticks(5);
        #1;
        en_run = 1'b0;
        enable = 1'b0;
        repeat (50) @(negedge clk);
        en_run = 1'b1;
        wait_ticks(OS - 5);
      end else begin
        wait_ticks(OS);
      end
    end
    ser_in = stop;
    wait_ticks(OS);
    ser_in = 1'b1;
  endtask

  function automatic void model_frame(input logic [7:0] d, input bit stop, input bit ack_at_load);
    if (stop) begin
      if (ack_at_load) m_ovr = 1'b0;
      else if (m_valid) m_ovr = 1'b1;
      m_byte  = d;
      m_valid = 1'b1;
    end else begin
      m_ferr++;
    end
  endfunction

  task automatic do_ack();
    @(negedge clk);
    rx_if.dout_ack = 1'b1;
    @(negedge clk);
    rx_if.dout_ack = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic check_state(input string tag);
    #1;
    chk({tag, "_byte"},  rx_if.dout_byte, m_byte);
    chk({tag, "_valid"}, rx_if.dout_valid, m_valid);
    chk({tag, "_ovr"},   rx_if.overrun, m_ovr);
    chk({tag, "_ferr"},  ferr_hi, m_ferr);
    chk({tag, "_busy"},  rx_busy, 1'b0);
  endtask

  // Raise dout_ack for exactly the clock on which the current frame loads:
  // the load tick lies LAT_DETECT ticks after the tick that left IDLE.
  task automatic ack_at_load(input int rises0);
    int guard = 0;
    bit hit = 1'b0;
    while (busy_rises == rises0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    guard = 0;
    while (!hit && guard < 2000) begin
      @(negedge clk);
      #1;
      if (enable && (tick_cnt + 1 == busy_rise_tick + LAT_DETECT)) begin
        rx_if.dout_ack = 1'b1;
        hit = 1'b1;
      end
      guard++;
    end
    chk("ack_at_load_found", hit, 1'b1);
    @(negedge clk);
    rx_if.dout_ack = 1'b0;
  endtask

  initial begin
    #30_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r0;
    int lat;
    logic [7:0] rd;
    bit rs;
    rx_if.dout_ack = 1'b0;

    // reset state
    repeat (4) @(negedge clk);
    #1;
    chk("rst_byte",  rx_if.dout_byte, 8'h00);
    chk("rst_valid", rx_if.dout_valid, 1'b0);
    chk("rst_ovr",   rx_if.overrun, 1'b0);
    chk("rst_ferr",  rx_if.frame_err, 1'b0);
    chk("rst_busy",  rx_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);

    // 1: basic frame, latency and busy/valid alignment
    r0 = valid_rises;
    send_frame(8'hAA, 1'b1, -1);
    model_frame(8'hAA, 1'b1, 1'b0);
    idle_bits(1);
    check_state("t1");
    chk("t1_rises", valid_rises, r0 + 1);
    lat = valid_rise_tick - last_start_tick;
    chk("t1_lat_edge_in_151_153", (lat >= LAT_DETECT - 1) && (lat <= LAT_DETECT + 1), 1'b1);
    chk("t1_lat_detect", valid_rise_tick - busy_rise_tick, LAT_DETECT);
    chk("t1_busy_falls_with_valid", rise_busy_fall, 1'b1);
    do_ack();

    // 2: glitch shorter than half a bit, then a good frame
    r0 = valid_rises;
    ser_in = 1'b0;
    wait_ticks(3);
    idle_bits(2);
    check_state("t2_glitch");
    chk("t2_no_valid", valid_rises, r0);
    send_frame(8'h5A, 1'b1, -1);
    model_frame(8'h5A, 1'b1, 1'b0);
    idle_bits(1);
    check_state("t2");
    do_ack();

    // 3: framing error, then recovery
    send_frame(8'h3C, 1'b0, -1);
    model_frame(8'h3C, 1'b0, 1'b0);
    idle_bits(2);
    check_state("t3_ferr");
    send_frame(8'h55, 1'b1, -1);
    model_frame(8'h55, 1'b1, 1'b0);
    idle_bits(1);
    check_state("t3");
    do_ack();

    // 4: overrun on back-to-back frames, cleared by ack
    send_frame(8'h12, 1'b1, -1);
    model_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, -1);
    model_frame(8'h34, 1'b1, 1'b0);
    idle_bits(1);
    check_state("t4");
    do_ack();
    #1;
    chk("t4_ack_valid", rx_if.dout_valid, 1'b0);
    chk("t4_ack_ovr",   rx_if.overrun, 1'b0);

    // 5: ack on the same clock as the second load
    send_frame(8'h12, 1'b1, -1);
    model_frame(8'h12, 1'b1, 1'b0);
    r0 = busy_rises;
    fork
      send_frame(8'h34, 1'b1, -1);
      ack_at_load(r0);
    join
    model_frame(8'h34, 1'b1, 1'b1);
    idle_bits(1);
    check_state("t5");

    // 6: asynchronous reset during data bit 4
    ser_in = 1'b0;
    wait_ticks(OS);
    rd = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      ser_in = rd[i];
      wait_ticks(OS);
    end
    ser_in = rd[4];
    wait_ticks(5);
    chk("t6_pre_busy", rx_busy, 1'b1);
    chk("t6_pre_valid", rx_if.dout_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy",  rx_busy, 1'b0);
    chk("t6_rst_valid", rx_if.dout_valid, 1'b0);
    chk("t6_rst_byte",  rx_if.dout_byte, 8'h00);
    chk("t6_rst_ovr",   rx_if.overrun, 1'b0);
    chk("t6_rst_ferr",  rx_if.frame_err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_byte = 8'h00;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    idle_bits(3);
    check_state("t6_after_rst");
    send_frame(8'hC3, 1'b1, 3);
    model_frame(8'hC3, 1'b1, 1'b0);
    idle_bits(1);
    check_state("t6_pause");
    do_ack();

    // random frames with random stop bits, gaps and acks
    for (int k = 0; k < 24; k++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rd, rs, -1);
      model_frame(rd, rs, 1'b0);
      idle_bits($urandom_range(1, 3));
      check_state($sformatf("rnd%0d", k));
      if ($urandom_range(0, 1) == 1) do_ack();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ua_receiver.md
Name: ua_receiver

Overview:
Asynchronous serial (8N1, LSB first) receiver. It is the companion of the UART transmitter in the FPGA_UART block.
- Samples `ser_in` using the same oversample `enable` tick scheme the transmitter uses.
- Validates the start bit at mid-bit and deserialises the data bits.
- Checks the stop bit.
- Presents the received byte with a valid/ack handshake to the consuming logic (host FIFO or command decoder).

Parameters:
- OVERSAMPLE, 16, number of `enable` ticks per bit period; must be even and ≥4.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, oversample tick; one clk cycle wide, asserted OVERSAMPLE times per bit period.
- ser_in, input, 1, serial line; idle high; asynchronous to clk.
- dout_byte, output, DATA_BITS, last correctly framed byte.
- dout_valid, output, 1, `dout_byte` holds an unconsumed byte.
- dout_ack, input, 1, consumer accepts the byte; clears `dout_valid`/`overrun`.
- frame_err, output, 1, one-clk pulse: stop bit sampled low.
- overrun, output, 1, sticky: a byte completed while `dout_valid` was 1 with no ack.
- rx_busy, output, 1, high whenever the FSM is not in IDLE.

Behaviour:
- **Reset (async, rst_n=0):**
  - FSM goes to IDLE; tick counter, bit index and shift register clear to 0.
  - `dout_byte`=0, `dout_valid`=0, `frame_err`=0, `overrun`=0, `rx_busy`=0.
  - Reset mid-frame abandons the frame; no output is produced for it.
- **Synchroniser:** `ser_in` passes through a 2-flop synchroniser (reset value 1) to give `rx_s`. All decisions use `rx_s`.
- **Clock gating:** the FSM and counters advance only on clk edges where `enable`=1. With `enable`=0 all state is frozen; handshake logic still runs every clk.
- **FSM states:**
  - IDLE: on a tick with `rx_s`=0, go to START and set cnt=0.
  - START: on each tick, cnt++. When cnt reaches OVERSAMPLE/2-1 (mid start bit):
    - `rx_s`=1: false start; return to IDLE with no output.
    - otherwise: set cnt=0, bit_idx=0, go to DATA.
  - DATA: on each tick, cnt++. When cnt reaches OVERSAMPLE-1:
    - shift `rx_s` in at the MSB (shift-right), so the first received bit ends up in bit 0;
    - set cnt=0 and bit_idx++;
    - after DATA_BITS samples, go to STOP.
  - STOP: on each tick, cnt++. When cnt reaches OVERSAMPLE-1 (mid stop bit):
    - `rx_s`=1: load `dout_byte` from the shift register and set `dout_valid`=1. If `dout_valid` was already 1 and `dout_ack` is not asserted this cycle, also set `overrun`=1.
    - `rx_s`=0: pulse `frame_err` for one clk; `dout_byte` and `dout_valid` are unchanged.
    - Either way, return to IDLE. Returning at mid stop bit permits back-to-back frames and resync.
- **Handshake:**
  - `dout_ack`=1 clears `dout_valid` and `overrun` on the next edge.
  - If ack and a new byte load occur in the same cycle, load wins: `dout_valid` stays 1, `dout_byte` takes the new value, and `overrun` is not set.
  - Ack while `dout_valid`=0 is ignored.
- **Overrun policy:** a new byte overwrites `dout_byte`; the older byte is lost.
- **Latency:**
  - From the start edge to `dout_valid`: 2 clk (synchroniser) + ticks to mid stop bit, i.e. OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE ticks, ±1 tick detection quantisation.
  - With defaults this is 152 ticks.
- **Counter widths:** cnt is clog2(OVERSAMPLE) bits; bit_idx is clog2(DATA_BITS+1) bits. No wrap occurs beyond the terminal values above.

Test Plan:
Bench uses OVERSAMPLE=16, DATA_BITS=8, clk period 320 ns, and `enable` pulsing one clk in every 4.
1. Send 0xAA framed 8N1 at 16 ticks/bit → `dout_byte`=0xAA and `dout_valid`=1 at 152±1 ticks after the start edge; `frame_err`=0, `overrun`=0, `rx_busy` falls the same cycle `dout_valid` rises.
2. Glitch: `ser_in` low for 3 ticks, then high → FSM returns to IDLE at the mid-start check; no `dout_valid`, no `frame_err`. A following frame 0x5A is received correctly.
3. Framing error: send 0x3C with stop bit 0 → one-clk `frame_err` pulse and `dout_valid` stays 0. After the line idles high, 0x55 is received correctly.
4. Overrun: send 0x12 then 0x34 back-to-back with no ack → `dout_byte`=0x34, `dout_valid`=1, `overrun`=1. Pulse `dout_ack` → both flags read 0 on the next clk.
5. Ack collision: assert `dout_ack` on the exact clk the second byte 0x34 loads → `dout_valid`=1, `dout_byte`=0x34, `overrun`=0.
6. Reset mid-frame: drive `rst_n`=0 for 2 clk during DATA bit 4 → all outputs 0 and `rx_busy`=0 immediately (asynchronous). A following 0xC3 frame is received correctly; holding `enable`=0 for 50 clk mid-frame delays completion without corrupting the byte.
